// File: rtl/tdc_pkg.sv
// Shared types and sizing for the delay-line TDC controller.
package tdc_pkg;

    localparam int NTDC     = 64;
    localparam int FRAC_W   = 10;
    localparam int CAL_LOG2 = 4;
    localparam int TO_MULT  = 4;

    typedef logic [NTDC-1:0] tdc_word_t;
    typedef logic [5:0]      tdc_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CAL_ACC,
        CAL_DIV,
        RUN
    } tdc_ctrl_state_e;

endpackage

// File: rtl/tdc_edge_find.sv
// First-rise / first-fall priority encoder over a TDC tap word.
// TDC_BUBBLE_FIX_EN adds a 3-tap majority filter ahead of the search.
module tdc_edge_find
    import tdc_pkg::*;
(
    input  tdc_word_t w,
    output tdc_idx_t  r,
    output tdc_idx_t  f,
    output logic      rf,
    output logic      ff
);

    tdc_word_t fw;

    always_comb begin
        fw = w;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 1; i < NTDC - 1; i++) begin
            fw[i] = (w[i-1] & w[i]) | (w[i] & w[i+1]) | (w[i-1] & w[i+1]);
        end
`endif
    end

    // Scan downward so the lowest matching index wins.
    always_comb begin
        r  = '0;
        f  = '0;
        rf = 1'b0;
        ff = 1'b0;
        for (int i = NTDC - 1; i >= 1; i--) begin
            if (!fw[i-1] && fw[i]) begin
                r  = tdc_idx_t'(i);
                rf = 1'b1;
            end
            if (fw[i-1] && !fw[i]) begin
                f  = tdc_idx_t'(i);
                ff = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC controller: 3-stage tap pipeline, period calibration, phase output.
// Define TDC_BUBBLE_FIX_EN to enable the single-tap bubble filter.
module tdc_ctrl
    import tdc_pkg::*;
(
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cal_start,
    input  logic [NTDC-1:0]   sampled_tdc,
    output logic [FRAC_W-1:0] tdc_frac,
    output logic              frac_valid,
    output logic              edge_miss,
    output logic [7:0]        period_est,
    output logic              cal_done,
    output logic              cal_fail
);

    localparam int INV_W  = FRAC_W + 7;
    localparam int DIV_N  = FRAC_W + 8;
    localparam int TO_CYC = TO_MULT << CAL_LOG2;
    localparam int TMO_W  = $clog2(TO_CYC) + 1;
    localparam int DCNT_W = $clog2(DIV_N);

    localparam logic [CAL_LOG2:0] GOOD_N   = (CAL_LOG2+1)'(1 << CAL_LOG2);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TO_CYC - 1);
    localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(DIV_N - 1);

    tdc_word_t       s1_word;
    tdc_idx_t        e_r, e_f, s2_r, s2_f;
    logic            e_rf, e_ff, s2_rf, s2_ff;
    tdc_ctrl_state_e state;

    logic [13:0]       acc;
    logic [CAL_LOG2:0] good;
    logic [TMO_W-1:0]  tmo;
    logic [INV_W-1:0]  inv;
    logic [DCNT_W-1:0] div_cnt;
    logic [8:0]        rem;

    tdc_edge_find u_edge (
        .w  (s1_word),
        .r  (e_r),
        .f  (e_f),
        .rf (e_rf),
        .ff (e_ff)
    );

    logic [5:0]         diff;
    logic [13:0]        acc_nxt;
    logic [CAL_LOG2:0]  good_nxt;
    logic               sample_ok;
    logic [8:0]         rem_sh, rem_sub;
    logic               qbit;
    logic [INV_W+5:0]   prod, scaled;

    always_comb begin
        diff      = (s2_r > s2_f) ? (s2_r - s2_f) : (s2_f - s2_r);
        acc_nxt   = acc + {7'b0, diff, 1'b0};
        good_nxt  = good + 1'b1;
        sample_ok = s2_rf & s2_ff;
        // Dividend is 2^(FRAC_W+7): its only set bit enters on step 0.
        rem_sh    = (rem << 1) | {8'b0, div_cnt == '0};
        rem_sub   = rem_sh - {1'b0, period_est};
        qbit      = rem_sh >= {1'b0, period_est};
        prod      = {{INV_W{1'b0}}, s2_r} * {6'b0, inv};
        scaled    = prod >> 7;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word    <= '0;
            s2_r       <= '0;
            s2_f       <= '0;
            s2_rf      <= 1'b0;
            s2_ff      <= 1'b0;
            state      <= IDLE;
            acc        <= '0;
            good       <= '0;
            tmo        <= '0;
            inv        <= '0;
            div_cnt    <= '0;
            rem        <= '0;
            tdc_frac   <= '0;
            frac_valid <= 1'b0;
            edge_miss  <= 1'b0;
            period_est <= '0;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
        end else begin
            s1_word    <= sampled_tdc;
            s2_r       <= e_r;
            s2_f       <= e_f;
            s2_rf      <= e_rf;
            s2_ff      <= e_ff;
            frac_valid <= 1'b0;
            edge_miss  <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                cal_done <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cal_start) begin
                            state    <= CAL_ACC;
                            acc      <= '0;
                            good     <= '0;
                            tmo      <= '0;
                            cal_fail <= 1'b0;
                            cal_done <= 1'b0;
                        end
                    end
                    CAL_ACC: begin
                        tmo <= tmo + 1'b1;
                        if (sample_ok) begin
                            acc  <= acc_nxt;
                            good <= good_nxt;
                        end
                        if (sample_ok && good_nxt == GOOD_N) begin
                            period_est <= acc_nxt[CAL_LOG2 +: 8];
                            div_cnt    <= '0;
                            rem        <= '0;
                            state      <= CAL_DIV;
                        end else if (tmo == TMO_LAST) begin
                            cal_fail <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    CAL_DIV: begin
                        if (period_est < 8'd2) begin
                            cal_fail <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            rem     <= qbit ? rem_sub : rem_sh;
                            inv     <= {inv[INV_W-2:0], qbit};
                            div_cnt <= div_cnt + 1'b1;
                            if (div_cnt == DIV_LAST) begin
                                cal_done <= 1'b1;
                                state    <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        frac_valid <= 1'b1;
                        if (s2_rf) begin
                            if (|scaled[INV_W+5:FRAC_W])
                                tdc_frac <= '1;
                            else
                                tdc_frac <= scaled[FRAC_W-1:0];
                        end else begin
                            edge_miss <= 1'b1;
                        end
                        if (cal_start) begin
                            state    <= CAL_ACC;
                            acc      <= '0;
                            good     <= '0;
                            tmo      <= '0;
                            cal_fail <= 1'b0;
                            cal_done <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Directed self-checking bench for tdc_ctrl.
module tb_tdc_ctrl;
    import tdc_pkg::*;

    logic        ref_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cal_start = 1'b0;
    logic [63:0] sampled_tdc = '0;
    logic [9:0]  tdc_frac;
    logic        frac_valid, edge_miss, cal_done, cal_fail;
    logic [7:0]  period_est;

    int total = 0;
    int bad = 0;

    localparam logic [63:0] W_CAL32 = 64'h0000_0000_00FF_FF00;
    localparam logic [63:0] W_CAL24 = 64'h0000_0000_0000_FFF0;
    localparam logic [63:0] W_R40   = 64'hFFFF_FF00_0000_0000;
    localparam logic [63:0] W_BUB   = 64'h0000_0000_00FF_FD00;

    tdc_ctrl dut (
        .ref_clk     (ref_clk),
        .rst_n       (rst_n),
        .en          (en),
        .cal_start   (cal_start),
        .sampled_tdc (sampled_tdc),
        .tdc_frac    (tdc_frac),
        .frac_valid  (frac_valid),
        .edge_miss   (edge_miss),
        .period_est  (period_est),
        .cal_done    (cal_done),
        .cal_fail    (cal_fail)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic step(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic pulse_cal();
        cal_start = 1'b1;
        step(1);
        cal_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!cal_done && n < limit) begin
            step(1);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        total++; if (tdc_frac !== 10'd0) begin bad++; $display("FAIL reset_frac got=%0d want=0", tdc_frac); end
        total++; if (frac_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", frac_valid); end
        total++; if (edge_miss !== 1'b0) begin bad++; $display("FAIL reset_miss got=%b want=0", edge_miss); end
        total++; if (period_est !== 8'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period_est); end
        total++; if (cal_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", cal_done); end
        total++; if (cal_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", cal_fail); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_calibration();
        int n;
        en = 1'b1;
        sampled_tdc = W_CAL32;
        step(3);
        total++; if (frac_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", frac_valid); end
        pulse_cal();
        wait_done(200, n);
        total++; if (n < 34 || n > 37) begin bad++; $display("FAIL cal_latency got=%0d want=34..37", n); end
        total++; if (period_est !== 8'd32) begin bad++; $display("FAIL cal_period got=%0d want=32", period_est); end
        total++; if (cal_fail !== 1'b0) begin bad++; $display("FAIL cal_fail got=%b want=0", cal_fail); end
        step(2);
        total++; if (tdc_frac !== 10'd256) begin bad++; $display("FAIL cal_frac got=%0d want=256", tdc_frac); end
        total++; if (frac_valid !== 1'b1) begin bad++; $display("FAIL cal_valid got=%b want=1", frac_valid); end
        total++; if (edge_miss !== 1'b0) begin bad++; $display("FAIL cal_miss got=%b want=0", edge_miss); end
    endtask

    task automatic test_saturation();
        sampled_tdc = W_R40;
        step(3);
        total++; if (tdc_frac !== 10'd1023) begin bad++; $display("FAIL sat_frac got=%0d want=1023", tdc_frac); end
        total++; if (edge_miss !== 1'b0) begin bad++; $display("FAIL sat_miss got=%b want=0", edge_miss); end
        sampled_tdc = '1;
        step(3);
        total++; if (edge_miss !== 1'b1) begin bad++; $display("FAIL ones_miss got=%b want=1", edge_miss); end
        total++; if (frac_valid !== 1'b1) begin bad++; $display("FAIL ones_valid got=%b want=1", frac_valid); end
        total++; if (tdc_frac !== 10'd1023) begin bad++; $display("FAIL ones_hold got=%0d want=1023", tdc_frac); end
    endtask

    task automatic test_recal();
        int n;
        sampled_tdc = W_CAL24;
        step(3);
        total++; if (tdc_frac !== 10'd128) begin bad++; $display("FAIL recal_old got=%0d want=128", tdc_frac); end
        pulse_cal();
        total++; if (cal_done !== 1'b0) begin bad++; $display("FAIL recal_drop got=%b want=0", cal_done); end
        total++; if (period_est !== 8'd32) begin bad++; $display("FAIL recal_hold got=%0d want=32", period_est); end
        wait_done(200, n);
        total++; if (n >= 200) begin bad++; $display("FAIL recal_wait got=%0d want<200", n); end
        total++; if (period_est !== 8'd24) begin bad++; $display("FAIL recal_period got=%0d want=24", period_est); end
        step(2);
        total++; if (tdc_frac !== 10'd170) begin bad++; $display("FAIL recal_frac got=%0d want=170", tdc_frac); end
    endtask

    task automatic test_en_abort();
        en = 1'b0;
        step(1);
        total++; if (frac_valid !== 1'b0) begin bad++; $display("FAIL en_valid got=%b want=0", frac_valid); end
        total++; if (cal_done !== 1'b0) begin bad++; $display("FAIL en_done got=%b want=0", cal_done); end
        total++; if (period_est !== 8'd24) begin bad++; $display("FAIL en_period got=%0d want=24", period_est); end
        total++; if (tdc_frac !== 10'd170) begin bad++; $display("FAIL en_frac got=%0d want=170", tdc_frac); end
        en = 1'b1;
        step(3);
        total++; if (frac_valid !== 1'b0) begin bad++; $display("FAIL en_idle got=%b want=0", frac_valid); end
    endtask

    task automatic test_timeout();
        int n;
        sampled_tdc = '0;
        step(3);
        pulse_cal();
        n = 0;
        while (!cal_fail && n < 100) begin
            step(1);
            n++;
        end
        total++; if (n !== 64) begin bad++; $display("FAIL tmo_cycles got=%0d want=64", n); end
        total++; if (cal_done !== 1'b0) begin bad++; $display("FAIL tmo_done got=%b want=0", cal_done); end
        step(5);
        total++; if (cal_fail !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", cal_fail); end
        total++; if (frac_valid !== 1'b0) begin bad++; $display("FAIL tmo_valid got=%b want=0", frac_valid); end
    endtask

    task automatic test_bubble();
        int n;
        logic [7:0] exp_p;
        logic [9:0] exp_f;
`ifdef TDC_BUBBLE_FIX_EN
        exp_p = 8'd32;
        exp_f = 10'd256;
`else
        exp_p = 8'd2;
        exp_f = 10'd1023;
`endif
        sampled_tdc = W_BUB;
        step(3);
        pulse_cal();
        total++; if (cal_fail !== 1'b0) begin bad++; $display("FAIL bub_clear got=%b want=0", cal_fail); end
        wait_done(200, n);
        total++; if (period_est !== exp_p) begin bad++; $display("FAIL bub_period got=%0d want=%0d", period_est, exp_p); end
        step(2);
        total++; if (tdc_frac !== exp_f) begin bad++; $display("FAIL bub_frac got=%0d want=%0d", tdc_frac, exp_f); end
    endtask

    task automatic test_async_reset();
        sampled_tdc = W_CAL32;
        step(3);
        pulse_cal();
        step(20);
        total++; if (period_est !== 8'd32) begin bad++; $display("FAIL div_period got=%0d want=32", period_est); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (period_est !== 8'd0) begin bad++; $display("FAIL arst_period got=%0d want=0", period_est); end
        total++; if (tdc_frac !== 10'd0) begin bad++; $display("FAIL arst_frac got=%0d want=0", tdc_frac); end
        total++; if (cal_done !== 1'b0 || cal_fail !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b want=00", cal_done, cal_fail); end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_saturation();
        test_recal();
        test_en_abort();
        test_timeout();
        test_bubble();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdc_ctrl.md
Name: tdc_ctrl

Overview:
- Digital controller for the 64-tap delay-line TDC. Runs in the ref_clk domain and registers the 64-bit TDC sample word every cycle.
- Decodes the rising and falling DCO edge positions in that word, then calibrates the DCO period in tap units.
- Outputs a normalized fractional phase word (DCO rising-edge delay / DCO period) per reference cycle for the DPLL phase detector.
- Owns the calibrate-then-run sequencing of the TDC.

Parameters:
- NTDC, 64, number of TDC taps (sample word width)
- FRAC_W, 10, fractional phase output width (full scale = one DCO period)
- CAL_LOG2, 4, log2 of number of period measurements averaged in calibration
- TO_MULT, 4, calibration timeout = TO_MULT * 2^CAL_LOG2 cycles

Ports:
- ref_clk  in  1  reference clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  controller enable; low forces IDLE
- cal_start  in  1  single-cycle request to (re)calibrate
- sampled_tdc  in  NTDC  raw TDC tap word
- tdc_frac  out  FRAC_W  fractional phase, unsigned, 0..2^FRAC_W-1
- frac_valid  out  1  tdc_frac updated this cycle
- edge_miss  out  1  no rising edge in window this sample (RUN only)
- period_est  out  8  calibrated DCO period in taps
- cal_done  out  1  level, high while a valid calibration is held
- cal_fail  out  1  sticky until next cal_start or reset

Behaviour:
- Reset: tdc_frac=0, frac_valid=0, edge_miss=0, period_est=0, cal_done=0, cal_fail=0, FSM=IDLE, pipeline cleared.
- Pipeline, all three stages advance every cycle:
  - S1 registers sampled_tdc (retiming off the async tap flops).
  - S2 decodes r = lowest i>=1 with w[i-1]=0, w[i]=1; f = lowest i>=1 with w[i-1]=1, w[i]=0; found flags rf/ff.
  - S3 produces output.
  - tdc_frac/frac_valid appear 3 cycles after the word is presented.
- FSM states IDLE, CAL_ACC, CAL_DIV, RUN:
  - IDLE: cal_start&en -> CAL_ACC; clears accumulator, counters, cal_fail, cal_done.
  - CAL_ACC: each S2 result with rf&ff adds 2*|r-f| to a 14-bit accumulator and increments the good count.
    - Good count = 2^CAL_LOG2 -> CAL_DIV; period_est = acc >> CAL_LOG2.
    - Timeout count reached first -> cal_fail=1, IDLE.
  - CAL_DIV: if period_est < 2, cal_fail=1 and go to IDLE.
    - Otherwise run a restoring divider: inv = floor(2^(FRAC_W+7) / period_est), one quotient bit per cycle, FRAC_W+8 cycles.
    - Then cal_done=1 -> RUN.
  - RUN: per cycle from S2:
    - If rf: tdc_frac = min((r*inv)>>7, 2^FRAC_W-1), frac_valid=1, edge_miss=0.
    - Else: tdc_frac held, frac_valid=1, edge_miss=1.
  - RUN with cal_start -> CAL_ACC; cal_done drops, period_est holds its old value until overwritten.
- en low in any state: -> IDLE next cycle; frac_valid=0, cal_done=0; period_est and tdc_frac hold; divider aborted.
- cal_start while in CAL_ACC/CAL_DIV is ignored.
- frac_valid=0 and edge_miss=0 outside RUN.
- Widths: r*inv product is 6+(FRAC_W+7) bits, unsigned. |r-f| is computed as unsigned difference of the larger minus the smaller.
- All-0 or all-1 word: rf=ff=0.

Optional Feature:
- TDC_BUBBLE_FIX_EN.
- Defined: S2 replaces each interior bit w[i] (1..NTDC-2) with majority(w[i-1], w[i], w[i+1]) before edge search; end bits pass through; latency unchanged.
- Undefined: raw S1 word is searched; a single-tap bubble yields an earlier edge.

Decomposition:
- Package tdc_pkg:
  - NTDC default, FRAC_W default
  - typedef tdc_word_t [NTDC-1:0]
  - typedef tdc_idx_t [5:0]
  - enum tdc_ctrl_state_e {IDLE, CAL_ACC, CAL_DIV, RUN}
- Sub-module tdc_edge_find: combinational bubble filter plus first-rise/first-fall priority encoder returning r, f, rf, ff. Also reusable by a future TDC monitor.

Test Plan:
- Calibration:
  - Stimulus: en=1, cal_start, then 16 words with 0s at taps 0..7, 1s at 8..23, 0s from 24 up.
  - Required: period_est=32, inv=4096, cal_done after 16+18+pipeline cycles.
  - Then in RUN: tdc_frac=256, frac_valid=1.
- Saturation/edge:
  - Stimulus: RUN with period_est=32, word with its only rise at r=40 (0s at 0..39, 1s from 40 up).
  - Required: (40*4096)>>7=1280 -> tdc_frac=1023.
  - Then an all-ones word: edge_miss=1, tdc_frac held at 1023.
- Timeout: cal_start with all-zero words. Required: cal_fail=1 after 64 cycles, FSM IDLE, cal_done=0.
- Bubble:
  - Stimulus: word rising at 8 with bit 9 forced 0.
  - With TDC_BUBBLE_FIX_EN: r=8.
  - Without: r=8, f=9, period sample 2 (check accumulator).
- Abort: rst_n low mid-CAL_DIV -> all outputs reset immediately (asynchronous). en low in RUN -> IDLE next cycle, frac_valid=0, period_est retained.
- Recalibration: in RUN, cal_start with 24-tap period (rise 4, fall 16). Required: cal_done drops, new period_est=24, inv=5461, r=4 -> tdc_frac=170.
